ace_snoop_responder: RTL and testbench

// - Cache-side end of the ACE snoop channel: accepts AC snoop requests from the CCU, looks the line up in the

---
 rtl/ace_snoop_responder.sv | 195 +++++++++++++++++++
 tb/tb_ace_snoop_responder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ace_snoop_responder.sv
// ACE snoop responder: accepts AC snoops, looks the line up in the local cache, answers on CR/CD and updates line state.
// Optional ACE_SNOOP_RESP_ERR_EN: unsupported ACSNOOP encodings answer with the Error bit set instead of an all-zero response.
module ace_snoop_responder #(
  parameter int unsigned AxiAddrWidth    = 64,
  parameter int unsigned AxiDataWidth    = 64,
  parameter int unsigned DcacheLineWidth = 512
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       ac_valid_i,
  output logic                       ac_ready_o,
  input  logic [AxiAddrWidth-1:0]    ac_addr_i,
  input  logic [3:0]                 ac_snoop_i,
  output logic                       cr_valid_o,
  input  logic                       cr_ready_i,
  output logic [4:0]                 cr_resp_o,
  output logic                       cd_valid_o,
  input  logic                       cd_ready_i,
  output logic [AxiDataWidth-1:0]    cd_data_o,
  output logic                       cd_last_o,
  output logic                       cache_req_o,
  input  logic                       cache_gnt_i,
  output logic [AxiAddrWidth-1:0]    cache_addr_o,
  input  logic                       cache_rvalid_i,
  input  logic                       cache_hit_i,
  input  logic                       cache_dirty_i,
  input  logic                       cache_shared_i,
  input  logic [DcacheLineWidth-1:0] cache_line_i,
  output logic                       cache_upd_o,
  output logic [1:0]                 cache_upd_op_o
);

  localparam int unsigned NumBeats = DcacheLineWidth / AxiDataWidth;
  localparam int unsigned BeatW    = (NumBeats > 1) ? $clog2(NumBeats) : 1;
  localparam int unsigned OffW     = $clog2(DcacheLineWidth / 8);
`ifdef ACE_SNOOP_RESP_ERR_EN
  localparam logic [4:0] UnsupResp = 5'b00010;
`else
  localparam logic [4:0] UnsupResp = 5'b00000;
`endif

  typedef enum logic [2:0] {IDLE, LOOKUP, WAIT, RESP, DATA} state_e;

  state_e                     state_q, state_d;
  logic [AxiAddrWidth-1:0]    addr_q, addr_d;
  logic [3:0]                 snoop_q, snoop_d;
  logic [4:0]                 resp_q, resp_d;
  logic [1:0]                 op_q, op_d;
  logic [DcacheLineWidth-1:0] line_q, line_d;
  logic [BeatW-1:0]           beat_q, beat_d;
  logic                       ac_ready_q, ac_ready_d;
  logic                       cache_req_q, cache_req_d;
  logic                       cr_valid_q, cr_valid_d;
  logic                       cd_valid_q, cd_valid_d;
  logic                       cd_last_q, cd_last_d;
  logic [AxiDataWidth-1:0]    cd_data_q, cd_data_d;

  function automatic logic is_supported(input logic [3:0] snp);
    case (snp)
      4'b0000, 4'b0001, 4'b0010, 4'b0011,
      4'b0111, 4'b1000, 4'b1001, 4'b1101: is_supported = 1'b1;
      default:                            is_supported = 1'b0;
    endcase
  endfunction

  // Returns {resp[4:0], op[1:0]}; resp = {WasUnique, IsShared, PassDirty, Error, DataTransfer}.
  function automatic logic [6:0] snoop_rsp(input logic [3:0] snp, input logic hit,
                                           input logic dirty, input logic shared);
    logic u;
    u = ~shared;
    snoop_rsp = '0;
    if (hit) begin
      case (snp)
        4'b0000:                   snoop_rsp = {u, 1'b1, 1'b0,  1'b0, 1'b1,  2'd0};
        4'b0001, 4'b0010, 4'b0011: snoop_rsp = {u, 1'b1, dirty, 1'b0, 1'b1,  2'd1};
        4'b0111:                   snoop_rsp = {u, 1'b0, dirty, 1'b0, 1'b1,  2'd3};
        4'b1000:                   snoop_rsp = {u, 1'b1, dirty, 1'b0, dirty, 2'd2};
        4'b1001:                   snoop_rsp = {u, 1'b0, dirty, 1'b0, dirty, 2'd3};
        4'b1101:                   snoop_rsp = {u, 1'b0, 1'b0,  1'b0, 1'b0,  2'd3};
        default:                   snoop_rsp = '0;
      endcase
    end
  endfunction

  // Next-state, captured data and registered output values.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    snoop_d = snoop_q;
    resp_d  = resp_q;
    op_d    = op_q;
    line_d  = line_q;
    beat_d  = beat_q;

    case (state_q)
      IDLE: begin
        if (ac_valid_i && ac_ready_q) begin
          addr_d             = ac_addr_i;
          addr_d[OffW-1:0]   = '0;
          snoop_d            = ac_snoop_i;
          if (is_supported(ac_snoop_i)) begin
            state_d = LOOKUP;
          end else begin
            // Unsupported encodings never touch the cache.
            resp_d  = UnsupResp;
            op_d    = 2'd0;
            state_d = RESP;
          end
        end
      end
      LOOKUP: if (cache_gnt_i) state_d = WAIT;
      WAIT: begin
        if (cache_rvalid_i) begin
          line_d          = cache_line_i;
          {resp_d, op_d}  = snoop_rsp(snoop_q, cache_hit_i, cache_dirty_i, cache_shared_i);
          state_d         = RESP;
        end
      end
      RESP: begin
        if (cr_ready_i) begin
          beat_d  = '0;
          state_d = resp_q[0] ? DATA : IDLE;
        end
      end
      DATA: begin
        if (cd_ready_i) begin
          if (beat_q == BeatW'(NumBeats - 1)) begin
            beat_d  = '0;
            state_d = IDLE;
          end else begin
            beat_d = beat_q + BeatW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    ac_ready_d  = (state_d == IDLE);
    cache_req_d = (state_d == LOOKUP);
    cr_valid_d  = (state_d == RESP);
    cd_valid_d  = (state_d == DATA);
    cd_last_d   = (state_d == DATA) && (beat_d == BeatW'(NumBeats - 1));
    cd_data_d   = '0;
    if (state_d == DATA) begin
      for (int unsigned k = 0; k < NumBeats; k++) begin
        if (beat_d == BeatW'(k)) cd_data_d = line_d[k*AxiDataWidth +: AxiDataWidth];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      snoop_q     <= '0;
      resp_q      <= '0;
      op_q        <= '0;
      line_q      <= '0;
      beat_q      <= '0;
      ac_ready_q  <= 1'b0;
      cache_req_q <= 1'b0;
      cr_valid_q  <= 1'b0;
      cd_valid_q  <= 1'b0;
      cd_last_q   <= 1'b0;
      cd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      snoop_q     <= snoop_d;
      resp_q      <= resp_d;
      op_q        <= op_d;
      line_q      <= line_d;
      beat_q      <= beat_d;
      ac_ready_q  <= ac_ready_d;
      cache_req_q <= cache_req_d;
      cr_valid_q  <= cr_valid_d;
      cd_valid_q  <= cd_valid_d;
      cd_last_q   <= cd_last_d;
      cd_data_q   <= cd_data_d;
    end
  end

  assign ac_ready_o     = ac_ready_q;
  assign cache_req_o    = cache_req_q;
  assign cache_addr_o   = addr_q;
  assign cr_valid_o     = cr_valid_q;
  assign cr_resp_o      = resp_q;
  assign cd_valid_o     = cd_valid_q;
  assign cd_last_o      = cd_last_q;
  assign cd_data_o      = cd_data_q;
  // The update strobe must coincide with the CR handshake, so it is decoded from it directly.
  assign cache_upd_o    = cr_valid_q && cr_ready_i && (op_q != 2'd0);
  assign cache_upd_op_o = op_q;

endmodule

// File: tb/tb_ace_snoop_responder.sv
// Directed bench for ace_snoop_responder: scoreboard queues for CR, CD beats and state updates.
module tb_ace_snoop_responder;

  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;
  localparam int unsigned LW = 512;
  localparam int unsigned NB = LW / DW;
`ifdef ACE_SNOOP_RESP_ERR_EN
  localparam logic [4:0] UnsupResp = 5'b00010;
`else
  localparam logic [4:0] UnsupResp = 5'b00000;
`endif

  logic          clk = 1'b0;
  logic          rst_i;
  logic          ac_valid_i, ac_ready_o;
  logic [AW-1:0] ac_addr_i;
  logic [3:0]    ac_snoop_i;
  logic          cr_valid_o, cr_ready_i;
  logic [4:0]    cr_resp_o;
  logic          cd_valid_o, cd_ready_i, cd_last_o;
  logic [DW-1:0] cd_data_o;
  logic          cache_req_o, cache_gnt_i, cache_rvalid_i;
  logic [AW-1:0] cache_addr_o;
  logic          cache_hit_i, cache_dirty_i, cache_shared_i;
  logic [LW-1:0] cache_line_i;
  logic          cache_upd_o;
  logic [1:0]    cache_upd_op_o;

  always #5 clk = ~clk;

  ace_snoop_responder #(.AxiAddrWidth(AW), .AxiDataWidth(DW), .DcacheLineWidth(LW)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .ac_valid_i(ac_valid_i), .ac_ready_o(ac_ready_o), .ac_addr_i(ac_addr_i), .ac_snoop_i(ac_snoop_i),
    .cr_valid_o(cr_valid_o), .cr_ready_i(cr_ready_i), .cr_resp_o(cr_resp_o),
    .cd_valid_o(cd_valid_o), .cd_ready_i(cd_ready_i), .cd_data_o(cd_data_o), .cd_last_o(cd_last_o),
    .cache_req_o(cache_req_o), .cache_gnt_i(cache_gnt_i), .cache_addr_o(cache_addr_o),
    .cache_rvalid_i(cache_rvalid_i), .cache_hit_i(cache_hit_i), .cache_dirty_i(cache_dirty_i),
    .cache_shared_i(cache_shared_i), .cache_line_i(cache_line_i),
    .cache_upd_o(cache_upd_o), .cache_upd_op_o(cache_upd_op_o)
  );

  int tests = 0;
  int fails = 0;
  logic [4:0]    exp_cr[$];
  logic [DW:0]   exp_cd[$];
  logic [1:0]    exp_op[$];
  int beats_seen = 0, upd_seen = 0, req_seen = 0;
  bit stall_en = 1'b0;
  bit cd_hold_low = 1'b0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] mk_line(input int seed);
    logic [LW-1:0] l;
    l = '0;
    for (int k = 0; k < NB; k++) l = l | (LW'({32'(seed), 32'(k)}) << (k * DW));
    return l;
  endfunction

  // Ready generators: with stall_en, each ready pulse is preceded by 0-5 stall cycles.
  initial begin
    int n;
    cr_ready_i = 1'b1;
    forever begin
      @(posedge clk); #1;
      n = stall_en ? int'($urandom_range(0, 5)) : 0;
      repeat (n) begin cr_ready_i = 1'b0; @(posedge clk); #1; end
      cr_ready_i = 1'b1;
    end
  end

  initial begin
    int n;
    cd_ready_i = 1'b1;
    forever begin
      @(posedge clk); #1;
      n = stall_en ? int'($urandom_range(0, 5)) : 0;
      repeat (n) begin cd_ready_i = 1'b0; @(posedge clk); #1; end
      cd_ready_i = !cd_hold_low;
    end
  end

  // Output monitor: scoreboard pops and hold-while-stalled checks.
  initial begin
    bit cr_pend, cd_pend;
    logic [4:0]  cr_prev;
    logic [DW:0] cd_prev;
    cr_pend = 1'b0; cd_pend = 1'b0; cr_prev = '0; cd_prev = '0;
    forever begin
      @(negedge clk);
      if (rst_i) begin
        cr_pend = 1'b0; cd_pend = 1'b0;
      end else begin
        if (cr_pend) chk("cr_hold", {cr_valid_o, cr_resp_o}, {1'b1, cr_prev});
        if (cd_pend) chk("cd_hold", {cd_valid_o, cd_last_o, cd_data_o}, {1'b1, cd_prev});
        if (cr_valid_o && cr_ready_i) begin
          if (exp_cr.size() == 0) chk("cr_extra", 32'(exp_cr.size()), 1);
          else chk("cr_resp", cr_resp_o, exp_cr.pop_front());
        end
        if (cd_valid_o && cd_ready_i) begin
          beats_seen++;
          if (exp_cd.size() == 0) chk("cd_extra", 32'(exp_cd.size()), 1);
          else chk("cd_beat", {cd_last_o, cd_data_o}, exp_cd.pop_front());
        end
        if (cache_upd_o) begin
          upd_seen++;
          chk("upd_on_cr_hs", {cr_valid_o, cr_ready_i}, 2'b11);
          if (exp_op.size() == 0) chk("upd_extra", 32'(exp_op.size()), 1);
          else chk("upd_op", cache_upd_op_o, exp_op.pop_front());
        end
        if (cache_req_o) req_seen++;
        cr_pend = cr_valid_o && !cr_ready_i;
        cr_prev = cr_resp_o;
        cd_pend = cd_valid_o && !cd_ready_i;
        cd_prev = {cd_last_o, cd_data_o};
      end
    end
  end

  task automatic issue(input logic [AW-1:0] addr, input logic [3:0] snp, input logic hit,
                       input logic dirty, input logic shared, input logic [LW-1:0] line,
                       input logic [4:0] eresp, input logic [1:0] eop, input bit lookup);
    int n;
    logic [AW-1:0] aligned;
    aligned = addr;
    aligned[5:0] = '0;
    exp_cr.push_back(eresp);
    if (eop != 2'd0) exp_op.push_back(eop);
    if (eresp[0]) begin
      for (int k = 0; k < NB; k++) exp_cd.push_back({k == NB - 1, DW'(line >> (k * DW))});
    end
    @(posedge clk); #1;
    ac_valid_i = 1'b1; ac_addr_i = addr; ac_snoop_i = snp;
    n = 0;
    do begin @(negedge clk); n++; end while (!ac_ready_o && n < 50);
    chk("ac_ready", ac_ready_o, 1'b1);
    @(posedge clk); #1;
    ac_valid_i = 1'b0;
    if (lookup) begin
      @(negedge clk);
      chk("req_latency", cache_req_o, 1'b1);
      chk("cache_addr", cache_addr_o, aligned);
      cache_gnt_i = 1'b1;
      @(posedge clk); #1;
      cache_gnt_i = 1'b0;
      cache_rvalid_i = 1'b1; cache_hit_i = hit; cache_dirty_i = dirty;
      cache_shared_i = shared; cache_line_i = line;
      @(negedge clk);
      chk("req_drop", cache_req_o, 1'b0);
      @(posedge clk); #1;
      cache_rvalid_i = 1'b0; cache_hit_i = 1'b0; cache_dirty_i = 1'b0; cache_shared_i = 1'b0;
    end
    @(negedge clk);
    chk("cr_latency", cr_valid_o, 1'b1);
  endtask

  task automatic run(input logic [AW-1:0] addr, input logic [3:0] snp, input logic hit,
                     input logic dirty, input logic shared, input int seed,
                     input logic [4:0] eresp, input logic [1:0] eop, input bit lookup);
    int n, b0, u0;
    b0 = beats_seen; u0 = upd_seen;
    issue(addr, snp, hit, dirty, shared, mk_line(seed), eresp, eop, lookup);
    n = 0;
    while ((exp_cr.size() != 0 || exp_cd.size() != 0 || exp_op.size() != 0) && n < 500) begin
      @(negedge clk); n++;
    end
    chk("drain_in_time", 32'(n < 500), 1);
    repeat (2) @(negedge clk);
    chk("beat_count", 32'(beats_seen - b0), eresp[0] ? NB : 0);
    chk("upd_count", 32'(upd_seen - u0), (eop != 2'd0) ? 1 : 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {ac_ready_o, cr_valid_o, cr_resp_o, cd_valid_o, cd_last_o,
              cache_req_o, cache_upd_o, cache_upd_op_o}, '0);
    chk({tag, "_data"}, {cd_data_o, cache_addr_o}, '0);
  endtask

  initial begin
    int n, r0;
    rst_i = 1'b1; ac_valid_i = 1'b0; ac_addr_i = '0; ac_snoop_i = '0;
    cache_gnt_i = 1'b0; cache_rvalid_i = 1'b0; cache_hit_i = 1'b0;
    cache_dirty_i = 1'b0; cache_shared_i = 1'b0; cache_line_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset_state");
    @(posedge clk); #1 rst_i = 1'b0;

    // ReadShared, hit dirty unique.
    run(64'h1040, 4'b0001, 1'b1, 1'b1, 1'b0, 0, 5'b11101, 2'd1, 1'b1);
    // ReadUnique miss.
    run(64'h2000, 4'b0111, 1'b0, 1'b0, 1'b0, 1, 5'b00000, 2'd0, 1'b1);
    // CleanInvalid hit clean shared.
    run(64'h3088, 4'b1001, 1'b1, 1'b0, 1'b1, 2, 5'b00000, 2'd3, 1'b1);

    stall_en = 1'b1;
    run(64'h4010, 4'b0111, 1'b1, 1'b0, 1'b0, 3, 5'b10001, 2'd3, 1'b1);
    run(64'h50ff, 4'b0000, 1'b1, 1'b1, 1'b1, 4, 5'b01001, 2'd0, 1'b1);
    run(64'h6040, 4'b1000, 1'b1, 1'b1, 1'b1, 5, 5'b01101, 2'd2, 1'b1);
    run(64'h7000, 4'b1101, 1'b1, 1'b1, 1'b0, 6, 5'b10000, 2'd3, 1'b1);
    run(64'h8040, 4'b0010, 1'b1, 1'b0, 1'b1, 7, 5'b01001, 2'd1, 1'b1);
    stall_en = 1'b0;

    // Unsupported encoding must never reach the cache.
    r0 = req_seen;
    run(64'h9000, 4'b1111, 1'b0, 1'b0, 1'b0, 8, UnsupResp, 2'd0, 1'b0);
    chk("unsup_no_req", 32'(req_seen - r0), 0);

    // Reset held 3 cycles while stuck in DATA.
    cd_hold_low = 1'b1;
    issue(64'hA000, 4'b0000, 1'b1, 1'b0, 1'b0, mk_line(9), 5'b11001, 2'd0, 1'b1);
    n = 0;
    while (!cd_valid_o && n < 50) begin @(negedge clk); n++; end
    chk("in_data_before_reset", cd_valid_o, 1'b1);
    @(posedge clk); #1 rst_i = 1'b1;
    exp_cr.delete(); exp_cd.delete(); exp_op.delete();
    cd_hold_low = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("mid_reset");
    @(posedge clk); #1 rst_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("ac_ready_after_reset", ac_ready_o, 1'b1);
    chk("no_cr_after_reset", {cr_valid_o, cd_valid_o}, 2'b00);

    // Recovery after the aborted transaction.
    run(64'h1040, 4'b0011, 1'b1, 1'b1, 1'b0, 10, 5'b11101, 2'd1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
